id_stage_queued: RTL and testbench

Decoupled, parametrised instruction-decode stage for the 5-stage RV32 pipeline, replacing the direct IF/ID hand-off. Fetched instructions enter a QDEPTH-entry queue through a valid/ready handshake. The head entry is decoded and checked against a per-register scoreboard for read-after-write hazards. Hazard-free instructions issue into a registered ID/EX output slot with its own valid/ready handshake. The stage owns the architectural register file, which is written by WB with same-cycle write-to-read bypass.

---
 rtl/id_stage_queued.sv | 387 ++++++++++++++++++++++++++++++++++++++
 tb/tb_id_stage_queued.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_queued.sv
// rtl/id_stage_queued.sv - queued RV32 decode stage with RAW scoreboard and register file
//
// Purpose:
//   Fetched instructions are buffered in a QDEPTH-entry circular queue. The
//   head entry is decoded and checked against a per-register pending
//   scoreboard. A hazard-free head issues into a registered ID/EX slot. The
//   stage holds the architectural register file, written by WB with a
//   same-cycle write-to-read bypass.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   if_valid/if_ready            IF handshake; if_inst, if_pc carry the payload
//   flush                        drop the queue and the output slot
//   wb_valid, wb_reg_wr          WB write strobe qualifiers
//   wb_dest_idx, wb_data         WB destination and data
//   id_valid/ex_ready            ID/EX handshake for the output slot
//   id_pc .. id_illegal          registered decoded instruction fields
//   id_raw_stall                 head is blocked by a pending source this cycle
//   q_count                      queue occupancy
module id_stage_queued #(
  parameter int QDEPTH = 4,
  parameter int XLEN   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_valid,
  output logic                    if_ready,
  input  logic [31:0]             if_inst,
  input  logic [XLEN-1:0]         if_pc,
  input  logic                    flush,
  input  logic                    wb_valid,
  input  logic                    wb_reg_wr,
  input  logic [4:0]              wb_dest_idx,
  input  logic [XLEN-1:0]         wb_data,
  output logic                    id_valid,
  input  logic                    ex_ready,
  output logic [XLEN-1:0]         id_pc,
  output logic [XLEN-1:0]         id_ra_value,
  output logic [XLEN-1:0]         id_rb_value,
  output logic [XLEN-1:0]         id_immediate,
  output logic [1:0]              id_opa_select,
  output logic [1:0]              id_opb_select,
  output logic [4:0]              id_alu_func,
  output logic [4:0]              id_dest_reg_idx,
  output logic [2:0]              id_funct3,
  output logic                    id_reg_wr,
  output logic                    id_rd_mem,
  output logic                    id_wr_mem,
  output logic                    id_cond_branch,
  output logic                    id_uncond_branch,
  output logic                    id_illegal,
  output logic                    id_raw_stall,
  output logic [$clog2(QDEPTH):0] q_count
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  // Operand select encodings
  localparam logic [1:0] OPA_RS1  = 2'd0;
  localparam logic [1:0] OPA_PC   = 2'd2;
  localparam logic [1:0] OPA_ZERO = 2'd3;
  localparam logic [1:0] OPB_RS2  = 2'd0;
  localparam logic [1:0] OPB_IMM  = 2'd1;

  // ALU function encodings
  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SUB    = 5'd1;
  localparam logic [4:0] ALU_SLT    = 5'd2;
  localparam logic [4:0] ALU_SLTU   = 5'd3;
  localparam logic [4:0] ALU_AND    = 5'd4;
  localparam logic [4:0] ALU_OR     = 5'd5;
  localparam logic [4:0] ALU_XOR    = 5'd6;
  localparam logic [4:0] ALU_SLL    = 5'd7;
  localparam logic [4:0] ALU_SRL    = 5'd8;
  localparam logic [4:0] ALU_SRA    = 5'd9;
  localparam logic [4:0] ALU_MUL    = 5'd10;
  localparam logic [4:0] ALU_MULH   = 5'd11;
  localparam logic [4:0] ALU_MULHSU = 5'd12;
  localparam logic [4:0] ALU_MULHU  = 5'd13;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;

  // Queue storage and bookkeeping
  logic [31:0]     inst_q [QDEPTH];
  logic [XLEN-1:0] pc_q   [QDEPTH];
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   count_q, count_d;

  // Scoreboard and register file
  logic [31:0]     pending_q, pending_d;
  logic [XLEN-1:0] rf_q [32];

  // Output slot
  logic            id_valid_q;
  logic [XLEN-1:0] id_pc_q, id_ra_value_q, id_rb_value_q, id_immediate_q;
  logic [1:0]      id_opa_select_q, id_opb_select_q;
  logic [4:0]      id_alu_func_q, id_dest_reg_idx_q;
  logic [2:0]      id_funct3_q;
  logic            id_reg_wr_q, id_rd_mem_q, id_wr_mem_q;
  logic            id_cond_branch_q, id_uncond_branch_q, id_illegal_q;

  // Head decode
  logic [31:0]     head_inst;
  logic [XLEN-1:0] head_pc;
  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [4:0]      rs1_idx, rs2_idx, rd_idx;
  logic [1:0]      dec_opa, dec_opb;
  logic [4:0]      dec_alu;
  logic [31:0]     dec_imm;
  logic            dec_wr, dec_rdm, dec_wrm, dec_cb, dec_ub, dec_ill;
  logic            use_rs1, use_rs2;

  logic            q_empty, q_full, push, issue, wb_wr, haz1, haz2, raw_stall;
  logic [XLEN-1:0] ra_val, rb_val;

  assign head_inst = inst_q[rd_ptr_q];
  assign head_pc   = pc_q[rd_ptr_q];
  assign opcode    = head_inst[6:0];
  assign f3        = head_inst[14:12];
  assign f7        = head_inst[31:25];
  assign rs1_idx   = head_inst[19:15];
  assign rs2_idx   = head_inst[24:20];
  assign rd_idx    = head_inst[11:7];

  always_comb begin
    dec_opa = OPA_RS1;
    dec_opb = OPB_RS2;
    dec_alu = ALU_ADD;
    dec_imm = 32'd0;
    dec_wr  = 1'b0;
    dec_rdm = 1'b0;
    dec_wrm = 1'b0;
    dec_cb  = 1'b0;
    dec_ub  = 1'b0;
    dec_ill = 1'b0;
    use_rs1 = 1'b1;
    use_rs2 = 1'b0;
    case (opcode)
      OP_LUI: begin
        dec_opa = OPA_ZERO;
        dec_opb = OPB_IMM;
        dec_imm = {head_inst[31:12], 12'd0};
        dec_wr  = 1'b1;
        use_rs1 = 1'b0;
      end
      OP_AUIPC: begin
        dec_opa = OPA_PC;
        dec_opb = OPB_IMM;
        dec_imm = {head_inst[31:12], 12'd0};
        dec_wr  = 1'b1;
        use_rs1 = 1'b0;
      end
      OP_JAL: begin
        dec_opa = OPA_PC;
        dec_opb = OPB_IMM;
        dec_imm = {{12{head_inst[31]}}, head_inst[19:12], head_inst[20],
                   head_inst[30:21], 1'b0};
        dec_wr  = 1'b1;
        dec_ub  = 1'b1;
        use_rs1 = 1'b0;
      end
      OP_JALR: begin
        dec_opb = OPB_IMM;
        dec_imm = {{20{head_inst[31]}}, head_inst[31:20]};
        dec_wr  = 1'b1;
        dec_ub  = 1'b1;
        dec_ill = (f3 != 3'b000);
      end
      OP_BRANCH: begin
        dec_opa = OPA_PC;
        dec_opb = OPB_IMM;
        dec_imm = {{20{head_inst[31]}}, head_inst[7], head_inst[30:25],
                   head_inst[11:8], 1'b0};
        dec_cb  = 1'b1;
        use_rs2 = 1'b1;
        dec_ill = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OP_LOAD: begin
        dec_opb = OPB_IMM;
        dec_imm = {{20{head_inst[31]}}, head_inst[31:20]};
        dec_rdm = 1'b1;
        dec_wr  = 1'b1;
        dec_ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OP_STORE: begin
        dec_opb = OPB_IMM;
        dec_imm = {{20{head_inst[31]}}, head_inst[31:25], head_inst[11:7]};
        dec_wrm = 1'b1;
        use_rs2 = 1'b1;
        dec_ill = (f3 > 3'b010);
      end
      OP_IMM: begin
        dec_opb = OPB_IMM;
        dec_imm = {{20{head_inst[31]}}, head_inst[31:20]};
        dec_wr  = 1'b1;
        case (f3)
          3'b000: dec_alu = ALU_ADD;
          3'b010: dec_alu = ALU_SLT;
          3'b011: dec_alu = ALU_SLTU;
          3'b100: dec_alu = ALU_XOR;
          3'b110: dec_alu = ALU_OR;
          3'b111: dec_alu = ALU_AND;
          3'b001: begin
            dec_alu = ALU_SLL;
            dec_ill = (f7 != 7'h00);
          end
          default: begin
            if (f7 == 7'h00)      dec_alu = ALU_SRL;
            else if (f7 == 7'h20) dec_alu = ALU_SRA;
            else                  dec_ill = 1'b1;
          end
        endcase
      end
      OP_REG: begin
        dec_wr  = 1'b1;
        use_rs2 = 1'b1;
        if (f7 == 7'h00) begin
          case (f3)
            3'b000:  dec_alu = ALU_ADD;
            3'b001:  dec_alu = ALU_SLL;
            3'b010:  dec_alu = ALU_SLT;
            3'b011:  dec_alu = ALU_SLTU;
            3'b100:  dec_alu = ALU_XOR;
            3'b101:  dec_alu = ALU_SRL;
            3'b110:  dec_alu = ALU_OR;
            default: dec_alu = ALU_AND;
          endcase
        end else if (f7 == 7'h20) begin
          if (f3 == 3'b000)      dec_alu = ALU_SUB;
          else if (f3 == 3'b101) dec_alu = ALU_SRA;
          else                   dec_ill = 1'b1;
        end else if (f7 == 7'h01) begin
          case (f3)
            3'b000:  dec_alu = ALU_MUL;
            3'b001:  dec_alu = ALU_MULH;
            3'b010:  dec_alu = ALU_MULHSU;
            3'b011:  dec_alu = ALU_MULHU;
            default: dec_ill = 1'b1;
          endcase
        end else begin
          dec_ill = 1'b1;
        end
      end
      default: dec_ill = 1'b1;
    endcase
    // An illegal instruction must have no architectural side effects.
    if (dec_ill) begin
      dec_wr  = 1'b0;
      dec_rdm = 1'b0;
      dec_wrm = 1'b0;
      dec_cb  = 1'b0;
      dec_ub  = 1'b0;
    end
  end

  assign wb_wr   = wb_valid & wb_reg_wr;
  assign q_empty = (count_q == '0);
  assign q_full  = (count_q == CW'(QDEPTH));

  // A source being written back this cycle is not a hazard: the bypass below
  // supplies the new value.
  assign haz1 = use_rs1 && (rs1_idx != 5'd0) && pending_q[rs1_idx] &&
                !(wb_wr && (wb_dest_idx == rs1_idx));
  assign haz2 = use_rs2 && (rs2_idx != 5'd0) && pending_q[rs2_idx] &&
                !(wb_wr && (wb_dest_idx == rs2_idx));
  assign raw_stall = !q_empty && (haz1 || haz2);

  assign ra_val = (rs1_idx == 5'd0) ? '0 :
                  (wb_wr && (wb_dest_idx == rs1_idx)) ? wb_data : rf_q[rs1_idx];
  assign rb_val = (rs2_idx == 5'd0) ? '0 :
                  (wb_wr && (wb_dest_idx == rs2_idx)) ? wb_data : rf_q[rs2_idx];

  // Full queue refuses even when a pop happens: no pass-through path.
  assign if_ready = !q_full && !flush;
  assign push     = if_valid && if_ready;
  assign issue    = !q_empty && !raw_stall && !flush && (!id_valid_q || ex_ready);
  assign count_d  = count_q + CW'(push) - CW'(issue);

  // Clear-then-set so an issue claiming rd wins over a WB retiring rd.
  always_comb begin
    pending_d = pending_q;
    if (wb_wr) pending_d[wb_dest_idx] = 1'b0;
    if (issue && dec_wr && (rd_idx != 5'd0)) pending_d[rd_idx] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q           <= '0;
      wr_ptr_q           <= '0;
      count_q            <= '0;
      pending_q          <= '0;
      id_valid_q         <= 1'b0;
      id_pc_q            <= '0;
      id_ra_value_q      <= '0;
      id_rb_value_q      <= '0;
      id_immediate_q     <= '0;
      id_opa_select_q    <= '0;
      id_opb_select_q    <= '0;
      id_alu_func_q      <= '0;
      id_dest_reg_idx_q  <= '0;
      id_funct3_q        <= '0;
      id_reg_wr_q        <= 1'b0;
      id_rd_mem_q        <= 1'b0;
      id_wr_mem_q        <= 1'b0;
      id_cond_branch_q   <= 1'b0;
      id_uncond_branch_q <= 1'b0;
      id_illegal_q       <= 1'b0;
      for (int i = 0; i < QDEPTH; i++) begin
        inst_q[i] <= '0;
        pc_q[i]   <= '0;
      end
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      // Older in-flight instructions still retire during a flush.
      pending_q <= pending_d;
      if (wb_wr && (wb_dest_idx != 5'd0)) rf_q[wb_dest_idx] <= wb_data;

      if (flush) begin
        count_q    <= '0;
        rd_ptr_q   <= wr_ptr_q;
        id_valid_q <= 1'b0;
      end else begin
        count_q <= count_d;
        if (push) begin
          inst_q[wr_ptr_q] <= if_inst;
          pc_q[wr_ptr_q]   <= if_pc;
          wr_ptr_q         <= wr_ptr_q + PW'(1);
        end
        if (issue) begin
          rd_ptr_q           <= rd_ptr_q + PW'(1);
          id_valid_q         <= 1'b1;
          id_pc_q            <= head_pc;
          id_ra_value_q      <= ra_val;
          id_rb_value_q      <= rb_val;
          id_immediate_q     <= XLEN'($signed(dec_imm));
          id_opa_select_q    <= dec_opa;
          id_opb_select_q    <= dec_opb;
          id_alu_func_q      <= dec_alu;
          id_dest_reg_idx_q  <= dec_wr ? rd_idx : 5'd0;
          id_funct3_q        <= f3;
          id_reg_wr_q        <= dec_wr;
          id_rd_mem_q        <= dec_rdm;
          id_wr_mem_q        <= dec_wrm;
          id_cond_branch_q   <= dec_cb;
          id_uncond_branch_q <= dec_ub;
          id_illegal_q       <= dec_ill;
        end else if (ex_ready) begin
          id_valid_q <= 1'b0;
        end
      end
    end
  end

  assign id_valid         = id_valid_q;
  assign id_pc            = id_pc_q;
  assign id_ra_value      = id_ra_value_q;
  assign id_rb_value      = id_rb_value_q;
  assign id_immediate     = id_immediate_q;
  assign id_opa_select    = id_opa_select_q;
  assign id_opb_select    = id_opb_select_q;
  assign id_alu_func      = id_alu_func_q;
  assign id_dest_reg_idx  = id_dest_reg_idx_q;
  assign id_funct3        = id_funct3_q;
  assign id_reg_wr        = id_reg_wr_q;
  assign id_rd_mem        = id_rd_mem_q;
  assign id_wr_mem        = id_wr_mem_q;
  assign id_cond_branch   = id_cond_branch_q;
  assign id_uncond_branch = id_uncond_branch_q;
  assign id_illegal       = id_illegal_q;
  assign id_raw_stall     = raw_stall;
  assign q_count          = count_q;

endmodule

// File: tb/tb_id_stage_queued.sv
// tb/tb_id_stage_queued.sv - self-checking bench for id_stage_queued
module tb_id_stage_queued;

  localparam int QD = 4;
  localparam int XL = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_valid, if_ready, flush;
  logic [31:0]   if_inst;
  logic [XL-1:0] if_pc;
  logic          wb_valid, wb_reg_wr;
  logic [4:0]    wb_dest_idx;
  logic [XL-1:0] wb_data;
  logic          id_valid, ex_ready;
  logic [XL-1:0] id_pc, id_ra_value, id_rb_value, id_immediate;
  logic [1:0]    id_opa_select, id_opb_select;
  logic [4:0]    id_alu_func, id_dest_reg_idx;
  logic [2:0]    id_funct3;
  logic          id_reg_wr, id_rd_mem, id_wr_mem, id_cond_branch, id_uncond_branch, id_illegal;
  logic          id_raw_stall;
  logic [2:0]    q_count;

  always #5 clk = ~clk;

  id_stage_queued #(.QDEPTH(QD), .XLEN(XL)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst), .if_pc(if_pc),
    .flush(flush),
    .wb_valid(wb_valid), .wb_reg_wr(wb_reg_wr), .wb_dest_idx(wb_dest_idx), .wb_data(wb_data),
    .id_valid(id_valid), .ex_ready(ex_ready),
    .id_pc(id_pc), .id_ra_value(id_ra_value), .id_rb_value(id_rb_value),
    .id_immediate(id_immediate),
    .id_opa_select(id_opa_select), .id_opb_select(id_opb_select),
    .id_alu_func(id_alu_func), .id_dest_reg_idx(id_dest_reg_idx), .id_funct3(id_funct3),
    .id_reg_wr(id_reg_wr), .id_rd_mem(id_rd_mem), .id_wr_mem(id_wr_mem),
    .id_cond_branch(id_cond_branch), .id_uncond_branch(id_uncond_branch),
    .id_illegal(id_illegal), .id_raw_stall(id_raw_stall), .q_count(q_count)
  );

  logic [150:0] dut_slot;
  assign dut_slot = {id_pc, id_ra_value, id_rb_value, id_immediate, id_opa_select,
                     id_opb_select, id_alu_func, id_dest_reg_idx, id_funct3, id_reg_wr,
                     id_rd_mem, id_wr_mem, id_cond_branch, id_uncond_branch, id_illegal};

  // One instruction as the generator built it, with the fields it must decode to.
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        u1, u2, wr;
    logic [1:0]  opa, opb;
    logic [4:0]  alu;
    logic [31:0] imm;
    logic        rdm, wrm, cb, ub, ill;
  } rec_t;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  rec_t         mq[$];
  logic         mv;
  logic [150:0] mslot;
  logic [31:0]  mpend;
  logic [31:0]  mrf[32];
  logic [4:0]   inflight[$];
  rec_t         nop;

  task automatic model_reset();
    mq.delete();
    inflight.delete();
    mv    = 1'b0;
    mslot = '0;
    mpend = '0;
    for (int i = 0; i < 32; i++) mrf[i] = '0;
  endtask

  // kinds: 0 addi, 1 add, 2 sub, 3 lw, 4 sw, 5 bne, 6 lui, 7 jal, 8 jalr, other illegal
  function automatic rec_t mk(input int kind, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [31:0] rnd);
    rec_t r;
    logic [11:0] i12;
    logic [12:0] b13;
    logic [19:0] u20;
    logic [20:0] j21;
    r   = '{default: '0};
    i12 = rnd[11:0];
    b13 = {rnd[12:1], 1'b0};
    u20 = rnd[19:0];
    j21 = {rnd[20:1], 1'b0};
    r.u1 = 1'b1;
    case (kind)
      0: begin r.inst = {i12, rs1, 3'b000, rd, 7'h13}; r.opb = 2'd1; r.wr = 1'b1;
               r.imm = {{20{i12[11]}}, i12}; end
      1: begin r.inst = {7'h00, rs2, rs1, 3'b000, rd, 7'h33}; r.u2 = 1'b1; r.wr = 1'b1; end
      2: begin r.inst = {7'h20, rs2, rs1, 3'b000, rd, 7'h33}; r.u2 = 1'b1; r.wr = 1'b1;
               r.alu = 5'd1; end
      3: begin r.inst = {i12, rs1, 3'b010, rd, 7'h03}; r.opb = 2'd1; r.wr = 1'b1; r.rdm = 1'b1;
               r.imm = {{20{i12[11]}}, i12}; end
      4: begin r.inst = {i12[11:5], rs2, rs1, 3'b010, i12[4:0], 7'h23}; r.opb = 2'd1;
               r.wrm = 1'b1; r.u2 = 1'b1; r.imm = {{20{i12[11]}}, i12}; end
      5: begin r.inst = {b13[12], b13[10:5], rs2, rs1, 3'b001, b13[4:1], b13[11], 7'h63};
               r.opa = 2'd2; r.opb = 2'd1; r.cb = 1'b1; r.u2 = 1'b1;
               r.imm = {{19{b13[12]}}, b13}; end
      6: begin r.inst = {u20, rd, 7'h37}; r.u1 = 1'b0; r.opa = 2'd3; r.opb = 2'd1;
               r.wr = 1'b1; r.imm = {u20, 12'h000}; end
      7: begin r.inst = {j21[20], j21[10:1], j21[11], j21[19:12], rd, 7'h6F}; r.u1 = 1'b0;
               r.opa = 2'd2; r.opb = 2'd1; r.wr = 1'b1; r.ub = 1'b1;
               r.imm = {{11{j21[20]}}, j21}; end
      8: begin r.inst = {i12, rs1, 3'b000, rd, 7'h67}; r.opb = 2'd1; r.wr = 1'b1; r.ub = 1'b1;
               r.imm = {{20{i12[11]}}, i12}; end
      default: begin r.inst = {7'h00, rs2, rs1, 3'b000, rd, 7'h7F}; r.ill = 1'b1; end
    endcase
    r.pc = rnd ^ 32'h1000_0000;
    return r;
  endfunction

  // One clock cycle: entered and left at posedge+1.
  task automatic cyc(input logic iv, input rec_t r, input logic fl, input logic er,
                     input logic wv, input logic ww, input logic [4:0] wd, input logic [31:0] wdat);
    logic hd, stall, rdy, iss, push, wbw;
    rec_t h;
    logic [4:0] s1, s2, rd;
    logic [31:0] va, vb;
    if_valid = iv; if_inst = r.inst; if_pc = r.pc; flush = fl; ex_ready = er;
    wb_valid = wv; wb_reg_wr = ww; wb_dest_idx = wd; wb_data = wdat;
    #1;
    h = '{default: '0};
    hd = (mq.size() > 0);
    wbw = wv && ww;
    stall = 1'b0; va = '0; vb = '0; s1 = '0; s2 = '0; rd = '0;
    if (hd) begin
      h  = mq[0];
      s1 = h.inst[19:15];
      s2 = h.inst[24:20];
      rd = h.inst[11:7];
      stall = (h.u1 && s1 != 0 && mpend[s1] && !(wbw && wd == s1)) ||
              (h.u2 && s2 != 0 && mpend[s2] && !(wbw && wd == s2));
      va = (s1 == 0) ? 32'd0 : (wbw && wd == s1) ? wdat : mrf[s1];
      vb = (s2 == 0) ? 32'd0 : (wbw && wd == s2) ? wdat : mrf[s2];
    end
    rdy  = (mq.size() < QD) && !fl;
    iss  = hd && !stall && !fl && (!mv || er);
    push = iv && rdy;
    check_eq("if_ready", 160'(if_ready), 160'(rdy));
    check_eq("raw_stall", 160'(id_raw_stall), 160'(stall));
    check_eq("q_count", 160'(q_count), 160'(mq.size()));
    if (wbw && wd != 0) begin
      mpend[wd] = 1'b0;
      mrf[wd]   = wdat;
    end
    if (iss) begin
      void'(mq.pop_front());
      mv = 1'b1;
      mslot = {h.pc, va, vb, h.imm, h.opa, h.opb, h.alu, (h.wr ? rd : 5'd0), h.inst[14:12],
               h.wr, h.rdm, h.wrm, h.cb, h.ub, h.ill};
      if (h.wr && rd != 0) begin
        mpend[rd] = 1'b1;
        inflight.push_back(rd);
      end
    end else if (mv && er) begin
      mv = 1'b0;
    end
    if (fl) begin
      mq.delete();
      mv = 1'b0;
    end
    if (push) mq.push_back(r);
    @(posedge clk);
    #1;
    check_eq("id_valid", 160'(id_valid), 160'(mv));
    check_eq("slot", 160'(dut_slot), 160'(mslot));
  endtask

  task automatic idle(input logic er, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, nop, 1'b0, er, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic push1(input rec_t r, input logic er);
    cyc(1'b1, r, 1'b0, er, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    nop = mk(0, 5'd0, 5'd0, 5'd0, 32'd0);
    rst = 1'b1;
    if_valid = 0; if_inst = '0; if_pc = '0; flush = 0; ex_ready = 0;
    wb_valid = 0; wb_reg_wr = 0; wb_dest_idx = '0; wb_data = '0;
    model_reset();
    #3;
    check_eq("rst_valid", 160'(id_valid), 160'(0));
    check_eq("rst_slot", 160'(dut_slot), 160'(0));
    check_eq("rst_qcount", 160'(q_count), 160'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Fill and wrap: EX stalled, six offers, then drain in order.
    for (int i = 0; i < 6; i++) push1(mk(0, 5'(10 + i), 5'd0, 5'd0, 32'(i + 1)), 1'b0);
    idle(1'b1, 7);

    // RAW stall resolved by WB with bypass.
    push1(mk(0, 5'd5, 5'd0, 5'd0, 32'd7), 1'b1);
    push1(mk(1, 5'd6, 5'd5, 5'd5, 32'd0), 1'b1);
    idle(1'b1, 4);
    cyc(1'b0, nop, 1'b0, 1'b1, 1'b1, 1'b1, 5'd5, 32'd7);
    idle(1'b1, 3);

    // Set/clear collision on x3.
    push1(mk(0, 5'd3, 5'd0, 5'd0, 32'd1), 1'b1);
    push1(mk(0, 5'd3, 5'd0, 5'd0, 32'd2), 1'b1);
    cyc(1'b1, mk(1, 5'd7, 5'd3, 5'd0, 32'd0), 1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 32'd11);
    idle(1'b1, 4);
    cyc(1'b0, nop, 1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 32'd22);
    idle(1'b1, 3);

    // Flush with three queued, slot full, and WB to x4 in the same cycle.
    push1(mk(0, 5'd4, 5'd0, 5'd0, 32'd5), 1'b0);
    for (int i = 0; i < 3; i++) push1(mk(0, 5'd9, 5'd0, 5'd0, 32'(i)), 1'b0);
    cyc(1'b1, mk(0, 5'd9, 5'd0, 5'd0, 32'd99), 1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 32'd9);
    push1(mk(1, 5'd8, 5'd4, 5'd4, 32'd0), 1'b1);
    idle(1'b1, 4);

    // Illegal opcode, write to x0, then a reader of x0.
    push1(mk(9, 5'd0, 5'd0, 5'd0, 32'd0), 1'b1);
    push1(mk(0, 5'd0, 5'd0, 5'd0, 32'd1), 1'b1);
    push1(mk(1, 5'd1, 5'd0, 5'd0, 32'd0), 1'b1);
    idle(1'b1, 4);

    // Reset mid-run with slot full and two queued.
    for (int i = 0; i < 3; i++) push1(mk(0, 5'(1 + i), 5'd0, 5'd0, 32'(i)), 1'b0);
    if_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_valid", 160'(id_valid), 160'(0));
    check_eq("arst_slot", 160'(dut_slot), 160'(0));
    check_eq("arst_qcount", 160'(q_count), 160'(0));
    check_eq("arst_stall", 160'(id_raw_stall), 160'(0));
    if_valid = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_eq("rel_if_ready", 160'(if_ready), 160'(1));
    @(posedge clk);
    #1;
    push1(mk(1, 5'd2, 5'd1, 5'd1, 32'd0), 1'b1);
    idle(1'b1, 3);

    // Randomized traffic with WB retiring issued writers in order.
    for (int n = 0; n < 2000; n++) begin
      rec_t r;
      logic wv, ww;
      logic [4:0] wd;
      r  = mk(int'($urandom_range(0, 9)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), $urandom);
      wv = 1'b0; ww = 1'b0; wd = 5'd0;
      if (inflight.size() > 0 && $urandom_range(0, 2) == 0) begin
        wv = 1'b1; ww = 1'b1; wd = inflight.pop_front();
      end else if ($urandom_range(0, 7) == 0) begin
        wv = 1'b1; ww = 1'($urandom_range(0, 1)); wd = 5'($urandom_range(0, 7));
      end
      cyc(1'($urandom_range(0, 3) != 0), r, 1'($urandom_range(0, 39) == 0),
          1'($urandom_range(0, 3) != 0), wv, ww, wd, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
